data_memory_responder: RTL and testbench

- Responder side of the CPU memory-stage load/store request interface.
- The CPU memory stage is the initiator and issues one request at a time.
- This block holds a word-organised data RAM and serves byte, half and word loads and stores after a fixed latency.
- It returns a response through a valid/ready handshake, with sign or zero extension and error flagging.
- It sits between the EX/MEM barrier and the MEM/WB barrier.

---
 rtl/data_memory_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Memory-stage load/store responder: word-organised data RAM serving byte/half/word
// accesses after a fixed latency, with a valid/ready response and error flagging.
module data_memory_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [31:0] reqAddress,
   input  logic [1:0]  reqSize,
   input  logic        reqUnsigned,
   input  logic [31:0] reqWriteData,
   output logic        respValid,
   input  logic        respReady,
   output logic [31:0] respReadData,
   output logic        respError
);

   localparam int AW       = $clog2(DEPTH_WORDS);
   localparam bit ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt;
   logic        accept, go_resp;

   logic        cap_write, cap_unsigned;
   logic [31:0] cap_address, cap_wdata;
   logic [1:0]  cap_size;

   logic        sel_write, sel_unsigned;
   logic [31:0] sel_address, sel_wdata;
   logic [1:0]  sel_size;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic          acc_error;
   logic [3:0]    lane_en;
   logic [31:0]   lane_data, word_rd, load_data;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next = state;
      reqReady   = 1'b0;
      accept     = 1'b0;
      go_resp    = 1'b0;
      unique case (state)
         IDLE: begin
            reqReady = 1'b1;
            if (reqValid) begin
               accept = 1'b1;
               if (ZERO_LAT) begin
                  state_next = RESP;
                  go_resp    = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               state_next = RESP;
               go_resp    = 1'b1;
            end
         end
         RESP: begin
            if (respReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign respValid = (state == RESP);

   // With zero latency the access happens on the accept edge, so the live request is used.
   always_comb begin
      if (state == IDLE) begin
         sel_write    = reqWrite;
         sel_unsigned = reqUnsigned;
         sel_address  = reqAddress;
         sel_wdata    = reqWriteData;
         sel_size     = reqSize;
      end else begin
         sel_write    = cap_write;
         sel_unsigned = cap_unsigned;
         sel_address  = cap_address;
         sel_wdata    = cap_wdata;
         sel_size     = cap_size;
      end
   end

   assign word_idx = sel_address[AW+1:2];
   assign lane     = sel_address[1:0];
   assign word_rd  = mem[word_idx];
   assign rd_byte  = word_rd[8*lane +: 8];
   assign rd_half  = lane[1] ? word_rd[31:16] : word_rd[15:0];

   always_comb begin
      acc_error = 1'b0;
      if (sel_size == 2'b11)                                      acc_error = 1'b1;
      else if ((sel_size == 2'b01) && lane[0])                    acc_error = 1'b1;
      else if ((sel_size == 2'b10) && (lane != 2'b00))            acc_error = 1'b1;
      else if ((sel_address >> (AW + 2)) != 32'd0)                acc_error = 1'b1;
   end

   always_comb begin
      lane_en   = 4'b0000;
      lane_data = 32'd0;
      load_data = 32'd0;
      unique case (sel_size)
         2'b00: begin
            lane_en   = 4'b0001 << lane;
            lane_data = {4{sel_wdata[7:0]}};
            load_data = {{24{~sel_unsigned & rd_byte[7]}}, rd_byte};
         end
         2'b01: begin
            lane_en   = lane[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{sel_wdata[15:0]}};
            load_data = {{16{~sel_unsigned & rd_half[15]}}, rd_half};
         end
         2'b10: begin
            lane_en   = 4'b1111;
            lane_data = sel_wdata;
            load_data = word_rd;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= 4'd0;
         respReadData <= 32'd0;
         respError    <= 1'b0;
         cap_write    <= 1'b0;
         cap_unsigned <= 1'b0;
         cap_address  <= 32'd0;
         cap_wdata    <= 32'd0;
         cap_size     <= 2'b00;
      end else begin
         if (accept) begin
            cap_write    <= reqWrite;
            cap_unsigned <= reqUnsigned;
            cap_address  <= reqAddress;
            cap_wdata    <= reqWriteData;
            cap_size     <= reqSize;
            cnt          <= 4'(LATENCY);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end

         if (go_resp) begin
            respError    <= acc_error;
            respReadData <= (acc_error || sel_write) ? 32'd0 : load_data;
         end else if ((state == RESP) && respReady) begin
            respError    <= 1'b0;
            respReadData <= 32'd0;
         end
      end
   end

   // NOTE: the RAM array has no reset; contents survive reset and only an in-flight store is dropped.
   always_ff @(posedge clk) begin
      if (!reset && go_resp && sel_write && !acc_error) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: expectations are queued at accept and
// compared by an independent monitor whenever a response is handed over.
module tb_data_memory_responder;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write, req_unsigned, resp_ready;
   logic [31:0] req_address, req_write_data;
   logic [1:0]  req_size;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_read_data;

   logic        req_valid0, req_write0, req_unsigned0, resp_ready0;
   logic [31:0] req_address0, req_write_data0;
   logic [1:0]  req_size0;
   logic        req_ready0, resp_valid0, resp_error0;
   logic [31:0] resp_read_data0;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .reqValid(req_valid), .reqReady(req_ready), .reqWrite(req_write),
      .reqAddress(req_address), .reqSize(req_size), .reqUnsigned(req_unsigned),
      .reqWriteData(req_write_data), .respValid(resp_valid), .respReady(resp_ready),
      .respReadData(resp_read_data), .respError(resp_error)
   );

   data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset),
      .reqValid(req_valid0), .reqReady(req_ready0), .reqWrite(req_write0),
      .reqAddress(req_address0), .reqSize(req_size0), .reqUnsigned(req_unsigned0),
      .reqWriteData(req_write_data0), .respValid(resp_valid0), .respReady(resp_ready0),
      .respReadData(resp_read_data0), .respError(resp_error0)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_timeout", req_ready, 1);
   endtask

   task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e);
      int lat;
      wait_ready();
      req_valid = 1'b1; req_write = w; req_address = a;
      req_size = sz; req_unsigned = u; req_write_data = wd;
      @(posedge clk);
      q.push_back('{exp_d, exp_e});
      #1;
      req_valid = 1'b0; req_write = ~w; req_address = 32'hFFFF_FFFF;
      req_size = 2'b11; req_unsigned = ~u; req_write_data = 32'h0;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 3);
      @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (!reset && resp_valid && resp_ready) begin
         if (q.size() == 0) begin
            check("unexpected_resp", resp_valid, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("resp_data", resp_read_data, e.data);
            check("resp_error", resp_error, e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1;
      req_valid = 0; req_write = 0; req_unsigned = 0; resp_ready = 1;
      req_address = 0; req_write_data = 0; req_size = 0;
      req_valid0 = 0; req_write0 = 0; req_unsigned0 = 0; resp_ready0 = 1;
      req_address0 = 0; req_write_data0 = 0; req_size0 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_read_data, 0);
      check("rst_resp_error", resp_error, 0);
      check("rst0_req_ready", req_ready0, 1);

      // Fill the whole RAM with a known pattern.
      for (int i = 0; i < 64; i++)
         do_req(1, 32'(i * 4), 2'b10, 0, 32'h1000_0000 + 32'(i), 0, 0);

      // Word store then loads with extension.
      do_req(1, 32'h10, 2'b10, 0, 32'hDEAD_BEEF, 0, 0);
      do_req(0, 32'h10, 2'b10, 1, 0, 32'hDEAD_BEEF, 0);
      do_req(0, 32'h13, 2'b00, 0, 0, 32'hFFFF_FFDE, 0);
      do_req(0, 32'h13, 2'b00, 1, 0, 32'h0000_00DE, 0);
      do_req(0, 32'h10, 2'b01, 0, 0, 32'hFFFF_BEEF, 0);
      do_req(0, 32'h12, 2'b01, 1, 0, 32'h0000_DEAD, 0);
      do_req(0, 32'h10, 2'b00, 0, 0, 32'hFFFF_FFEF, 0);
      do_req(0, 32'h11, 2'b00, 1, 0, 32'h0000_00BE, 0);

      // Partial stores with garbage in the unused upper data bits.
      do_req(1, 32'h11, 2'b00, 0, 32'hFFFF_FF55, 0, 0);
      do_req(0, 32'h10, 2'b10, 0, 0, 32'hDEAD_55EF, 0);
      do_req(1, 32'h12, 2'b01, 0, 32'hABCD_1234, 0, 0);
      do_req(0, 32'h10, 2'b10, 0, 0, 32'h1234_55EF, 0);

      // Error cases.
      do_req(0, 32'h12, 2'b10, 0, 0, 0, 1);
      do_req(0, 32'h11, 2'b01, 0, 0, 0, 1);
      do_req(0, 32'h10, 2'b11, 0, 0, 0, 1);
      do_req(1, 32'h12, 2'b10, 0, 32'hFFFF_FFFF, 0, 1);
      do_req(1, 32'h100, 2'b10, 0, 32'hBAD0_BAD0, 0, 1);
      do_req(1, 32'h101, 2'b00, 0, 32'h0000_00AA, 0, 1);
      do_req(0, 32'h100, 2'b10, 0, 0, 0, 1);
      do_req(0, 32'hFC, 2'b10, 0, 0, 32'h1000_003F, 0);

      // Backpressure: response held while a busy-time request is offered.
      wait_ready();
      resp_ready = 1'b0;
      req_valid = 1'b1; req_write = 0; req_address = 32'h10; req_size = 2'b10;
      req_unsigned = 0;
      @(posedge clk);
      q.push_back('{32'h1234_55EF, 1'b0});
      #1;
      req_write = 1; req_write_data = 32'hFFFF_FFFF;
      n = 1;
      @(negedge clk);
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_latency", n, 3);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", resp_valid, 1);
         check("bp_data", resp_read_data, 32'h1234_55EF);
         check("bp_error", resp_error, 0);
         check("bp_req_ready", req_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("bp_release_ready", req_ready, 1);
      check("bp_release_valid", resp_valid, 0);
      do_req(0, 32'h10, 2'b10, 0, 0, 32'h1234_55EF, 0);

      // Reset during WAIT of a store drops it.
      do_req(1, 32'h20, 2'b10, 0, 32'h0000_0000, 0, 0);
      wait_ready();
      req_valid = 1'b1; req_write = 1; req_address = 32'h20; req_size = 2'b10;
      req_write_data = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_mid_valid", resp_valid, 0);
         check("rst_mid_ready", req_ready, 1);
      end
      do_req(0, 32'h20, 2'b10, 0, 0, 32'h0000_0000, 0);

      // Every word must still hold what was last legally stored.
      for (int i = 0; i < 64; i++) begin
         logic [31:0] exp_w;
         if (i == 4)      exp_w = 32'h1234_55EF;
         else if (i == 8) exp_w = 32'h0000_0000;
         else             exp_w = 32'h1000_0000 + 32'(i);
         do_req(0, 32'(i * 4), 2'b10, 0, 0, exp_w, 0);
      end

      // Zero-latency instance: response on the cycle after the accept edge.
      @(negedge clk);
      req_valid0 = 1'b1; req_write0 = 1; req_address0 = 32'h4; req_size0 = 2'b10;
      req_write_data0 = 32'h89AB_CDEF;
      @(posedge clk);
      #1 req_valid0 = 1'b0;
      @(negedge clk);
      check("lat0_store_valid", resp_valid0, 1);
      check("lat0_store_error", resp_error0, 0);
      check("lat0_store_data", resp_read_data0, 0);
      check("lat0_busy_ready", req_ready0, 0);
      @(posedge clk);
      @(negedge clk);
      check("lat0_idle_valid", resp_valid0, 0);
      check("lat0_idle_ready", req_ready0, 1);
      req_valid0 = 1'b1; req_write0 = 0; req_address0 = 32'h6; req_size0 = 2'b00;
      req_unsigned0 = 0;
      @(posedge clk);
      #1 req_valid0 = 1'b0;
      @(negedge clk);
      check("lat0_load_valid", resp_valid0, 1);
      check("lat0_load_data", resp_read_data0, 32'hFFFF_FFAB);
      @(posedge clk);

      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) check("pending_responses", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
